scan_display_ctrl: RTL and testbench
====================================

# scan_display_ctrl

Parametrised, time-multiplexed seven-segment display controller for a bank of `DIGITS` common-anode digits. It is the next-generation replacement for fixed four-digit scan drivers fed by a derived 1 kHz clock. The prescaler runs on the system clock, and the block adds:
- double-buffered display updates with a valid/ready write port,
- per-digit blanking and decimal points,
- 16-level PWM brightness.

It sits between application logic and the board's anode/segment pins.

## Interface
- `DIGITS`, 8, number of digits scanned (1..16).
- `CLK_HZ`, 100_000_000, system clock frequency.
- `SCAN_HZ`, 1000, digit-slot rate. `CLK_HZ` must be divisible by `16*SCAN_HZ`.

Reset is synchronous and active-high.

- `clk` input 1: system clock; all logic on its rising edge.
- `rst_` input 1: synchronous, active-high reset.
- `wr_valid` input 1: write request.
- `wr_ready` output 1: write port can accept.
- `wr_data` input 4*DIGITS: hex nibble per digit; digit i = `[4i+3:4i]`.
- `wr_dp` input DIGITS: decimal point per digit, 1 = lit.
- `wr_en` input DIGITS: digit enable, 0 = blanked.
- `brightness` input 4: duty level, sampled every cycle.
- `an` output DIGITS: anode drive, active-low; `an[i]` = digit i.
- `seg` output 8: segment drive, active-low; `seg[0]`=a … `seg[6]`=g, `seg[7]`=dp.
- `frame_start` output 1: one-cycle pulse when digit 0's slot begins.

## Operation
- **Prescaler:** counts 0..SUB_DIV-1, where SUB_DIV = CLK_HZ/(16*SCAN_HZ), and emits `sub_tick` on the terminal count.
- **Phase counter:** 4 bits, 0..15, advances on `sub_tick`.
- **Digit index:** $clog2(DIGITS) bits (minimum 1). It advances when the phase wraps 15→0 and wraps from DIGITS-1 to 0.
- **Write buffers:**
  - Pending buffer {data, dp, en} plus flag `pend_full`.
  - `wr_ready` = !`pend_full`.
  - Handshake fires on `wr_valid && wr_ready`: operands are captured and `pend_full` is set.
- **Frame swap:**
  - Occurs on the cycle the index wraps to 0, which is the cycle `frame_start` is asserted.
  - If `pend_full`: pending is copied to the active buffer and `pend_full` is cleared.
  - No write is accepted during the swap cycle, because `wr_ready` is already low.
  - The display never tears mid-frame.
- **Drive for current digit k:**
  - `an[k]` = 0 iff `active_en[k]` and phase ≤ `brightness`, giving duty (b+1)/16. All other anodes are 1.
  - `seg[6:0]` = hex glyph of `active_data[k]`.
  - `seg[7]` = ~`active_dp[k]`.
  - Glyphs: 0–9 standard, A, b, C, d, E, F.
- `brightness` changes take effect at the next phase comparison. There is no buffering.

## Timing
- All outputs are registered.
- `an`/`seg`/`frame_start` reflect counter state with 1-cycle latency.
- **Reset values:**
  - `an` = all 1.
  - `seg` = 8'hFF.
  - `wr_ready` = 1.
  - `frame_start` = 0.
  - Counters = 0.
  - Active and pending buffers = 0, with `active_en` = 0, so the display is blank.
- After reset, the first `frame_start` occurs after DIGITS*16*SUB_DIV cycles.
- Slot length is 16*SUB_DIV cycles; frame length is DIGITS times that.
- Write-to-display latency: the write is accepted, then shown from the next `frame_start` onward. The worst case is one full frame plus 1 cycle.
- Reset asserted mid-operation: all state returns to reset values on the following edge and the pending write is discarded.
- Reset has priority over handshake and swap.
- With `DIGITS`=1, the index stays 0 and `frame_start` pulses on every phase wrap.

## Structure
- Package `display_pkg`:
  - 8-bit glyph constants for hex 0–F (active-low).
  - The localparam formula for SUB_DIV.
  - A `seg_t` typedef.
- Sub-module `seg7_hex_decode`: combinational nibble → 7-bit active-low glyph, instantiated once on the muxed nibble.
- Prescaler, phase/index counters, buffers and output registers stay in the top module.

## Test plan
Use `DIGITS`=4, `CLK_HZ`=32, `SCAN_HZ`=1. This gives SUB_DIV=2, a 32-cycle slot and a 128-cycle frame.

1. **Reset:** hold `rst_`=1 for 3 cycles, then release → `an`=4'hF, `seg`=8'hFF, `wr_ready`=1, `frame_start` first pulses 128 cycles after release.
2. **Basic display:** write `wr_data`=16'h3210, `wr_en`=4'hF, `wr_dp`=4'b0001, `brightness`=15 → from the next frame, two checks hold:
   - Digit 0 slot: `an`=4'b1110, `seg`=8'h40.
   - Digit 1 slot: `an`=4'b1101, `seg`=8'hF9.
3. **Brightness:** `brightness`=3 → `an[k]` is low for exactly 8 of 32 cycles per slot (phases 0–3), and high for the rest.
4. **Backpressure:** assert back-to-back writes A then B → the following sequence is required:
   - A is accepted.
   - `wr_ready` stays 0 until A's `frame_start`, then returns to 1.
   - B is accepted.
   - A is shown for frame N and B from frame N+1.
5. **Blanking:** `wr_en`=4'b1011 → `an[2]` stays 1 for its entire slot at any brightness, while the other digits scan normally.
6. **Mid-frame reset:** assert `rst_` during digit 2's slot with a pending write → the next cycle shows `an`=4'hF and `seg`=8'hFF, `wr_ready`=1, and the old data never reappears.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   seg_t          : 8-bit active-low segment word, [0]=a .. [6]=g, [7]=dp
//   GLYPH_0..F     : hex glyphs with the decimal point off (bit 7 = 1)
//   calc_sub_div() : prescaler divide ratio so that 16 PWM phases make one digit slot
package display_pkg;

  typedef logic [7:0] seg_t;

  localparam int PHASES = 16;

  localparam seg_t GLYPH_0 = 8'hC0;
  localparam seg_t GLYPH_1 = 8'hF9;
  localparam seg_t GLYPH_2 = 8'hA4;
  localparam seg_t GLYPH_3 = 8'hB0;
  localparam seg_t GLYPH_4 = 8'h99;
  localparam seg_t GLYPH_5 = 8'h92;
  localparam seg_t GLYPH_6 = 8'h82;
  localparam seg_t GLYPH_7 = 8'hF8;
  localparam seg_t GLYPH_8 = 8'h80;
  localparam seg_t GLYPH_9 = 8'h90;
  localparam seg_t GLYPH_A = 8'h88;
  localparam seg_t GLYPH_B = 8'h83;
  localparam seg_t GLYPH_C = 8'hC6;
  localparam seg_t GLYPH_D = 8'hA1;
  localparam seg_t GLYPH_E = 8'h86;
  localparam seg_t GLYPH_F = 8'h8E;

  function automatic int calc_sub_div(input int clk_hz, input int scan_hz);
    return clk_hz / (PHASES * scan_hz);
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to seven-segment glyph (active-low).
//   nibble : input  [3:0] hex value
//   glyph  : output [6:0] segments g..a, 0 = lit
module seg7_hex_decode
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = GLYPH_0[6:0];
    case (nibble)
      4'h0: glyph = GLYPH_0[6:0];
      4'h1: glyph = GLYPH_1[6:0];
      4'h2: glyph = GLYPH_2[6:0];
      4'h3: glyph = GLYPH_3[6:0];
      4'h4: glyph = GLYPH_4[6:0];
      4'h5: glyph = GLYPH_5[6:0];
      4'h6: glyph = GLYPH_6[6:0];
      4'h7: glyph = GLYPH_7[6:0];
      4'h8: glyph = GLYPH_8[6:0];
      4'h9: glyph = GLYPH_9[6:0];
      4'hA: glyph = GLYPH_A[6:0];
      4'hB: glyph = GLYPH_B[6:0];
      4'hC: glyph = GLYPH_C[6:0];
      4'hD: glyph = GLYPH_D[6:0];
      4'hE: glyph = GLYPH_E[6:0];
      4'hF: glyph = GLYPH_F[6:0];
    endcase
  end

endmodule

// File: rtl/scan_display_ctrl.sv
// Time-multiplexed seven-segment controller for DIGITS common-anode digits,
// with double-buffered updates, per-digit blanking/dp and 16-level PWM.
//   clk, rst_            : clock, synchronous active-high reset
//   wr_valid/wr_ready    : write handshake into the pending buffer
//   wr_data/wr_dp/wr_en  : nibble, decimal point and enable per digit
//   brightness           : duty level, digit lit for phases 0..brightness
//   an                   : anode drive, active-low
//   seg                  : segment drive, active-low, [7] = dp
//   frame_start          : one-cycle pulse as digit 0's slot begins
module scan_display_ctrl
  import display_pkg::*;
#(
  parameter int DIGITS  = 8,
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [4*DIGITS-1:0]   wr_data,
  input  logic [DIGITS-1:0]     wr_dp,
  input  logic [DIGITS-1:0]     wr_en,
  input  logic [3:0]            brightness,
  output logic [DIGITS-1:0]     an,
  output seg_t                  seg,
  output logic                  frame_start
);

  localparam int SUB_DIV = calc_sub_div(CLK_HZ, SCAN_HZ);
  localparam int PW      = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PW-1:0] presc_q;
  logic [3:0]    phase_q;
  logic [IW-1:0] idx_q;

  logic sub_tick, phase_wrap, frame_wrap;

  assign sub_tick   = (presc_q == PW'(SUB_DIV - 1));
  assign phase_wrap = sub_tick && (phase_q == 4'hF);
  assign frame_wrap = phase_wrap && (idx_q == IW'(DIGITS - 1));

  always_ff @(posedge clk) begin
    if (rst_) begin
      presc_q <= '0;
      phase_q <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= sub_tick ? '0 : presc_q + PW'(1);
      if (sub_tick)
        phase_q <= phase_q + 4'd1;
      if (phase_wrap)
        idx_q <= frame_wrap ? '0 : idx_q + IW'(1);
    end
  end

  logic [4*DIGITS-1:0] pend_data, act_data;
  logic [DIGITS-1:0]   pend_dp, pend_en, act_dp, act_en;
  logic                pend_full;

  assign wr_ready = !pend_full;

  // Swap and accept are exclusive: a swap needs pend_full, which holds wr_ready low.
  always_ff @(posedge clk) begin
    if (rst_) begin
      pend_data <= '0;
      pend_dp   <= '0;
      pend_en   <= '0;
      pend_full <= 1'b0;
      act_data  <= '0;
      act_dp    <= '0;
      act_en    <= '0;
    end else if (frame_wrap && pend_full) begin
      act_data  <= pend_data;
      act_dp    <= pend_dp;
      act_en    <= pend_en;
      pend_full <= 1'b0;
    end else if (wr_valid && !pend_full) begin
      pend_data <= wr_data;
      pend_dp   <= wr_dp;
      pend_en   <= wr_en;
      pend_full <= 1'b1;
    end
  end

  logic [3:0]        cur_nibble;
  logic [6:0]        cur_glyph;
  logic              lit;
  logic [DIGITS-1:0] an_d;

  assign cur_nibble = act_data[{idx_q, 2'b00} +: 4];
  assign lit        = act_en[idx_q] && (phase_q <= brightness);

  seg7_hex_decode u_decode (
    .nibble (cur_nibble),
    .glyph  (cur_glyph)
  );

  always_comb begin
    an_d = '1;
    if (lit)
      an_d[idx_q] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      an          <= '1;
      seg         <= 8'hFF;
      frame_start <= 1'b0;
    end else begin
      an          <= an_d;
      seg         <= {~act_dp[idx_q], cur_glyph};
      frame_start <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_scan_display_ctrl.sv
module tb_scan_display_ctrl;

  localparam int DIGITS  = 4;
  localparam int CLK_HZ  = 32;
  localparam int SCAN_HZ = 1;
  localparam int SUB_DIV = 2;
  localparam int SLOT    = 16 * SUB_DIV;
  localparam int FRAME   = DIGITS * SLOT;

  // Lit segments per hex digit, active-high gfedcba.
  localparam logic [6:0] SEG_ON [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        rst_ = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_data = '0;
  logic [3:0]  wr_dp = '0;
  logic [3:0]  wr_en = '0;
  logic [3:0]  brightness = 4'd15;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame_start;

  scan_display_ctrl #(.DIGITS(DIGITS), .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ)) dut (
    .clk         (clk),
    .rst_        (rst_),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .wr_dp       (wr_dp),
    .wr_en       (wr_en),
    .brightness  (brightness),
    .an          (an),
    .seg         (seg),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
    logic       ready;
    logic       fs;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: time since reset decides digit and phase; buffers are
  // tracked as whole transactions.
  int          m_t = 0;
  logic        m_pf = 1'b0;
  logic [15:0] m_pd = '0, m_ad = '0;
  logic [3:0]  m_pdp = '0, m_pen = '0, m_adp = '0, m_aen = '0;

  always @(posedge clk) begin : model
    exp_t e;
    int total, k, ph;
    logic [3:0] nib;
    if (rst_) begin
      m_t = 0; m_pf = 1'b0;
      m_pd = '0; m_pdp = '0; m_pen = '0;
      m_ad = '0; m_adp = '0; m_aen = '0;
      e.an = 4'hF; e.seg = 8'hFF; e.ready = 1'b1; e.fs = 1'b0;
    end else begin
      total = m_t % FRAME;
      k     = total / SLOT;
      ph    = (total % SLOT) / SUB_DIV;
      nib   = m_ad[4*k +: 4];
      e.an  = (m_aen[k] && ph <= int'(brightness)) ? ~(4'b0001 << k) : 4'hF;
      e.seg = {~m_adp[k], ~SEG_ON[nib]};
      e.fs  = (total == FRAME - 1);
      if (e.fs && m_pf) begin
        m_ad = m_pd; m_adp = m_pdp; m_aen = m_pen; m_pf = 1'b0;
      end else if (wr_valid && !m_pf) begin
        m_pd = wr_data; m_pdp = wr_dp; m_pen = wr_en; m_pf = 1'b1;
      end
      e.ready = !m_pf;
      m_t++;
    end
    exp_q.push_back(e);
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("an", {4'h0, an}, {4'h0, e.an});
      chk("seg", seg, e.seg);
      chk("wr_ready", {7'h0, wr_ready}, {7'h0, e.ready});
      chk("frame_start", {7'h0, frame_start}, {7'h0, e.fs});
    end
  end

  task automatic do_write(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
    int n;
    wr_data = d; wr_dp = dp; wr_en = en; wr_valid = 1'b1;
    n = 0;
    while (!wr_ready && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!wr_ready) begin
      errors++;
      $display("FAIL write_accept got wr_ready=0 after %0d cycles expected 1", n);
    end
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_frame(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 3 * FRAME);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst_ = 1'b0;

    // First frame_start latency after reset release.
    wait_frame(n);
    checks++;
    if (!frame_start || n != FRAME) begin
      errors++;
      $display("FAIL first_frame_start got %0d cycles expected %0d", n, FRAME);
    end

    // Basic display at full brightness.
    brightness = 4'd15;
    do_write(16'h3210, 4'b0001, 4'hF);
    repeat (2 * FRAME + 10) @(negedge clk);

    // Reduced brightness.
    brightness = 4'd3;
    repeat (FRAME + 20) @(negedge clk);

    // Back-to-back writes: second waits for the first to be swapped in.
    brightness = 4'd15;
    do_write(16'h7654, 4'b0000, 4'hF);
    do_write(16'hFEDC, 4'b1010, 4'hF);
    repeat (2 * FRAME + 10) @(negedge clk);

    // Blanked digit 2.
    do_write(16'hBA98, 4'b0100, 4'b1011);
    repeat (FRAME + 40) @(negedge clk);
    brightness = 4'd7;
    repeat (FRAME) @(negedge clk);

    // Reset during digit 2's slot with a write pending.
    wait_frame(n);
    do_write(16'h5555, 4'hF, 4'hF);
    repeat (70) @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
    rst_ = 1'b0;
    repeat (2 * FRAME + 10) @(negedge clk);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      wr_valid = ($urandom_range(0, 5) == 0);
      wr_data  = 16'($urandom);
      wr_dp    = 4'($urandom);
      wr_en    = 4'($urandom);
      if ($urandom_range(0, 15) == 0) brightness = 4'($urandom_range(0, 15));
      rst_ = ($urandom_range(0, 699) == 0);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    rst_ = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
